// File: rtl/fifo_sync_ram.sv
// ============================================================================
// Module   : fifo_sync_ram
// Purpose  : Single-clock FWFT FIFO on an inferred simple-dual-port RAM with a
//            registered prefetch stage. Define FIFO_SYNC_RAM_ERR_EN to add the
//            sticky ovf/udf flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync_ram #(
   parameter int AWIDTH     = 9,
   parameter int DWIDTH     = 8,
   parameter int AFULL_LVL  = (1 << AWIDTH) - 4,
   parameter int AEMPTY_LVL = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic              wr_ena,
   output logic              full,
   output logic              afull,
   output logic [DWIDTH-1:0] rd_data,
   input  logic              rd_ena,
   output logic              empty,
   output logic              aempty,
   output logic [AWIDTH:0]   level
`ifdef FIFO_SYNC_RAM_ERR_EN
   ,
   output logic              ovf,
   output logic              udf
`endif
);

   localparam logic [AWIDTH:0] c_depth  = (AWIDTH+1)'(1 << AWIDTH);
   localparam logic [AWIDTH:0] c_afull  = (AWIDTH+1)'(AFULL_LVL);
   localparam logic [AWIDTH:0] c_aempty = (AWIDTH+1)'(AEMPTY_LVL);

   logic [DWIDTH-1:0] mem_q [0:(1<<AWIDTH)-1];
   logic [DWIDTH-1:0] ram_dat_q;

   logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [AWIDTH:0]   level_q, level_d;
   logic              ram_vld_q, ram_vld_d;
   logic              out_vld_q, out_vld_d;
   logic [DWIDTH-1:0] out_dat_q, out_dat_d;

   logic              push, pop;
   logic              ram_to_out, ram_rd;
   logic [AWIDTH:0]   ram_cnt;

   always_comb begin
      push       = wr_ena & ~full;
      pop        = rd_ena & out_vld_q;
      // Words still in the RAM array, excluding the two prefetch registers.
      ram_cnt    = level_q - (AWIDTH+1)'(ram_vld_q) - (AWIDTH+1)'(out_vld_q);
      ram_to_out = ram_vld_q & (~out_vld_q | pop);
      ram_rd     = (ram_cnt != '0) & (~ram_vld_q | ram_to_out);

      out_vld_d  = ram_to_out | (out_vld_q & ~pop);
      out_dat_d  = ram_to_out ? ram_dat_q : out_dat_q;
      ram_vld_d  = ram_rd | (ram_vld_q & ~ram_to_out);
      wr_ptr_d   = wr_ptr_q + AWIDTH'(push);
      rd_ptr_d   = rd_ptr_q + AWIDTH'(ram_rd);

      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
      if (ram_rd) ram_dat_q <= mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         ram_vld_q <= 1'b0;
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         ram_vld_q <= ram_vld_d;
         out_vld_q <= out_vld_d;
         out_dat_q <= out_dat_d;
      end
   end

   always_comb begin
      full    = (level_q == c_depth);
      afull   = (level_q >= c_afull);
      aempty  = (level_q <= c_aempty);
      empty   = ~out_vld_q;
      rd_data = out_dat_q;
      level   = level_q;
   end

`ifdef FIFO_SYNC_RAM_ERR_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   always_comb begin
      ovf_d = ovf_q | (wr_ena & full);
      udf_d = udf_q | (rd_ena & ~out_vld_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign ovf = ovf_q;
   assign udf = udf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_ram.sv
// ============================================================================
// Module   : tb_fifo_sync_ram
// Purpose  : Directed self-checking bench for fifo_sync_ram (AWIDTH=4) with a
//            queue scoreboard and an independent FWFT visibility model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_sync_ram;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;
   localparam int AFL   = 12;
   localparam int AEL   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ena = 1'b0;
   logic          rd_ena = 1'b0;
   logic          full, afull, empty, aempty;
   logic [DW-1:0] rd_data;
   logic [AW:0]   level;
`ifdef FIFO_SYNC_RAM_ERR_EN
   logic          ovf, udf;
   bit            m_ovf, m_udf;
`endif

   fifo_sync_ram #(.AWIDTH(AW), .DWIDTH(DW), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_ena(wr_ena), .full(full),
      .afull(afull), .rd_data(rd_data), .rd_ena(rd_ena), .empty(empty),
      .aempty(aempty), .level(level)
`ifdef FIFO_SYNC_RAM_ERR_EN
      , .ovf(ovf), .udf(udf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [DW-1:0] d; int t; } ent_t;
   ent_t q[$];
   int   edge_n  = 0;
   int   m_level = 0;
   int   total   = 0;
   int   passed  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // A head word becomes visible two edges after the edge that wrote it.
   function automatic bit m_empty();
      return (q.size() == 0) || (edge_n < q[0].t + 2);
   endfunction

   task automatic check_all();
      chk("level", level, m_level);
      chk("full", full, (m_level == DEPTH));
      chk("afull", afull, (m_level >= AFL));
      chk("aempty", aempty, (m_level <= AEL));
      chk("empty", empty, m_empty());
      if (!m_empty()) chk("head", rd_data, q[0].d);
`ifdef FIFO_SYNC_RAM_ERR_EN
      chk("ovf", ovf, m_ovf);
      chk("udf", udf, m_udf);
`endif
   endtask

   task automatic tick();
      bit            push_ok, pop_ok;
      logic [DW-1:0] d;
      push_ok = wr_ena && (m_level < DEPTH);
      pop_ok  = rd_ena && !m_empty();
      d       = wr_data;
      if (pop_ok && !rst) chk("pop_data", rd_data, q[0].d);
`ifdef FIFO_SYNC_RAM_ERR_EN
      if (wr_ena && m_level == DEPTH) m_ovf = 1'b1;
      if (rd_ena && m_empty())        m_udf = 1'b1;
`endif
      @(posedge clk);
      edge_n++;
      if (rst) begin
         q.delete();
         m_level = 0;
`ifdef FIFO_SYNC_RAM_ERR_EN
         m_ovf = 1'b0;
         m_udf = 1'b0;
`endif
      end else begin
         if (pop_ok)  begin void'(q.pop_front()); m_level--; end
         if (push_ok) begin q.push_back('{d, edge_n}); m_level++; end
      end
      #1;
      check_all();
   endtask

   task automatic drain();
      wr_ena = 1'b0;
      rd_ena = 1'b1;
      for (int i = 0; i < 4 * DEPTH && m_level != 0; i++) tick();
      rd_ena = 1'b0;
      tick();
      chk("drain_level", level, 0);
      chk("drain_empty", empty, 1);
   endtask

   initial begin
      // Reset, then idle
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_rd_data", rd_data, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_rd_data", rd_data, 0);
      end

      // Fill 0x01..0x10, then one dropped push
      wr_ena = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         wr_data = DW'(i);
         tick();
      end
      chk("fill_full", full, 1);
      chk("fill_level", level, 16);
      chk("fill_afull", afull, 1);
      wr_data = 8'hFF;
      tick();
      chk("drop_level", level, 16);
      drain();

      // Single push latency
      wr_ena  = 1'b1;
      wr_data = 8'hA5;
      tick();
      wr_ena = 1'b0;
      chk("lat_level_k", level, 1);
      chk("lat_empty_k", empty, 1);
      tick();
      chk("lat_empty_k1", empty, 1);
      tick();
      chk("lat_empty_k2", empty, 0);
      chk("lat_data_k2", rd_data, 8'hA5);
      drain();

      // Streaming at level 3
      wr_ena = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = DW'(8'h20 + i);
         tick();
      end
      wr_ena = 1'b0;
      tick();
      tick();
      wr_ena = 1'b1;
      rd_ena = 1'b1;
      for (int i = 0; i < 100; i++) begin
         wr_data = DW'(8'h23 + i);
         tick();
         chk("stream_level", level, 3);
      end
      drain();

      // Push and pop together at full
      wr_ena = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         wr_data = DW'(8'h40 + i);
         tick();
      end
      wr_ena = 1'b0;
      tick();
      tick();
      wr_ena  = 1'b1;
      rd_ena  = 1'b1;
      wr_data = 8'hEE;
      tick();
      wr_ena = 1'b0;
      rd_ena = 1'b0;
      chk("full_pp_level", level, DEPTH - 1);
      chk("full_pp_full", full, 0);
`ifdef FIFO_SYNC_RAM_ERR_EN
      chk("full_pp_ovf", ovf, 1);
`endif
      drain();

      // Reset mid-operation with wr_ena held
      wr_ena = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_data = DW'(8'h60 + i);
         tick();
      end
      rst     = 1'b1;
      wr_data = 8'h77;
      tick();
      rst    = 1'b0;
      wr_ena = 1'b0;
      chk("mrst_level", level, 0);
      chk("mrst_empty", empty, 1);
      chk("mrst_aempty", aempty, 1);
      chk("mrst_rd_data", rd_data, 0);
      wr_ena  = 1'b1;
      wr_data = 8'h5A;
      tick();
      wr_ena = 1'b0;
      chk("mrst_empty_k", empty, 1);
      tick();
      chk("mrst_empty_k1", empty, 1);
      tick();
      chk("mrst_empty_k2", empty, 0);
      chk("mrst_data_k2", rd_data, 8'h5A);
      chk("mrst_level_k2", level, 1);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
